// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_ctrl                                                |
// | Description : Hazard and stall controller for a 5-stage MIPS pipeline.   |
// |               Produces PC / pipeline-register write enables, IF/ID and   |
// |               ID/EX flushes and a redirect bubble flag from register     |
// |               dependences, branch misprediction and memory handshakes.   |
// |               Keeps a pending-redirect flag across memory freezes and    |
// |               three saturating performance counters.                     |
// | Ports       : clk, rst_n (async, active low)                             |
// |               id_*   : ID-stage source registers / usage / branch / jr    |
// |               ex_*   : EX-stage regwrite, load, destination, mispredict   |
// |               mem_*  : MEM-stage regwrite, load, destination             |
// |               imem_ready, dmem_ready : memory handshakes                 |
// |               perf_clr : synchronous counter clear                       |
// |               *_write, *_flush, bubble : pipeline control outputs        |
// |               stall_cnt, flush_cnt, freeze_cnt : performance counters    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int RAW       = 5,
  parameter int ZERO_SKIP = 1,
  parameter int PCNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RAW-1:0]    id_rs,
  input  logic [RAW-1:0]    id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_branch,
  input  logic              id_jr,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [RAW-1:0]    ex_wsel,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic [RAW-1:0]    mem_wsel,
  input  logic              ex_mispredict,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  input  logic              perf_clr,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              exmem_write,
  output logic              memwb_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              bubble,
  output logic [PCNT_W-1:0] stall_cnt,
  output logic [PCNT_W-1:0] flush_cnt,
  output logic [PCNT_W-1:0] freeze_cnt
);

  localparam logic [PCNT_W-1:0] C_CNT_ONE = {{(PCNT_W-1){1'b0}}, 1'b1};
  localparam logic [PCNT_W-1:0] C_CNT_MAX = {PCNT_W{1'b1}};

  // Register state
  logic              pend_q, pend_d;
  logic [PCNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PCNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [PCNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

  // Destination qualifiers: with the r0 exemption a zero destination can
  // never match, so the hazard terms below need no further special casing.
  logic w_ex_nz;
  logic w_mem_nz;

  generate
    if (ZERO_SKIP != 0) begin : g_zero_skip
      assign w_ex_nz  = |ex_wsel;
      assign w_mem_nz = |mem_wsel;
    end else begin : g_no_zero_skip
      assign w_ex_nz  = 1'b1;
      assign w_mem_nz = 1'b1;
    end
  endgenerate

  logic w_match_ex;
  logic w_match_mem;

  assign w_match_ex  = w_ex_nz &&
                       (((ex_wsel == id_rs) && id_use_rs) ||
                        ((ex_wsel == id_rt) && id_use_rt));
  assign w_match_mem = w_mem_nz &&
                       (((mem_wsel == id_rs) && id_use_rs) ||
                        ((mem_wsel == id_rt) && id_use_rt));

  // Hazard terms
  logic w_freeze;
  logic w_redir;
  logic w_lu;
  logic w_bx;
  logic w_bm;
  logic w_stall;
  logic w_stall_active;

  assign w_freeze = !imem_ready || !dmem_ready;
  // A mispredict seen during a freeze is remembered in pend_q so the
  // redirect still happens on the first unfrozen cycle.
  assign w_redir  = (ex_mispredict || pend_q) && !w_freeze;
  assign w_lu     = ex_memread && ex_regwrite && w_match_ex;
  assign w_bx     = id_branch && ex_regwrite && w_match_ex;
  assign w_bm     = id_branch && mem_memread && mem_regwrite && w_match_mem;
  assign w_stall  = w_lu || w_bx || w_bm;

  // Stall only counts when it actually drives the outputs.
  assign w_stall_active = w_stall && !w_freeze && !w_redir;

  // Pipeline control outputs, strict priority:
  // freeze > redirect > stall > jr slot kill > normal.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    bubble      = 1'b0;

    if (w_freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else if (w_redir) begin
      // The ID instruction is on the wrong path, so any stall it would
      // cause is irrelevant.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      bubble     = 1'b1;
    end else if (w_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jr) begin
      // Kill the sequentially fetched instruction behind the jr.
      ifid_flush = 1'b1;
    end
  end

  // Pending redirect and counters next-state
  always_comb begin
    pend_d       = pend_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;

    if (w_freeze) begin
      if (ex_mispredict) begin
        pend_d = 1'b1;
      end
    end else begin
      pend_d = 1'b0;
    end

    if (perf_clr) begin
      stall_cnt_d  = '0;
      flush_cnt_d  = '0;
      freeze_cnt_d = '0;
    end else begin
      if (w_stall_active && (stall_cnt_q != C_CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + C_CNT_ONE;
      end
      if (w_redir && (flush_cnt_q != C_CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + C_CNT_ONE;
      end
      if (w_freeze && (freeze_cnt_q != C_CNT_MAX)) begin
        freeze_cnt_d = freeze_cnt_q + C_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      pend_q       <= pend_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hazard_ctrl                                             |
// | Description : Directed self-checking bench for hazard_ctrl. Three        |
// |               instances share one stimulus: default parameters,          |
// |               ZERO_SKIP=0, and PCNT_W=2 for counter saturation.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_hazard_ctrl;

  localparam logic [7:0] C_NORM   = 8'hF8; // all enables, no flush
  localparam logic [7:0] C_STALL  = 8'h3A; // pc/ifid held, idex flushed
  localparam logic [7:0] C_FREEZE = 8'h00; // everything held
  localparam logic [7:0] C_REDIR  = 8'hFF; // all enables, both flushes, bubble
  localparam logic [7:0] C_JR     = 8'hFC; // all enables, ifid flushed

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_wsel, mem_wsel;
  logic       id_use_rs, id_use_rt, id_branch, id_jr;
  logic       ex_regwrite, ex_memread, mem_regwrite, mem_memread;
  logic       ex_mispredict, imem_ready, dmem_ready, perf_clr;

  logic        a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_iff, a_idf, a_bub;
  logic [15:0] a_stall, a_flush, a_freeze;
  logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_iff, b_idf, b_bub;
  logic [15:0] b_stall, b_flush, b_freeze;
  logic        c_pc, c_ifid, c_idex, c_exmem, c_memwb, c_iff, c_idf, c_bub;
  logic [1:0]  c_stall, c_flush, c_freeze;

  logic [7:0] a_ctl, b_ctl, c_ctl;
  assign a_ctl = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_iff, a_idf, a_bub};
  assign b_ctl = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_iff, b_idf, b_bub};
  assign c_ctl = {c_pc, c_ifid, c_idex, c_exmem, c_memwb, c_iff, c_idf, c_bub};

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl #(.RAW(5), .ZERO_SKIP(1), .PCNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch), .id_jr(id_jr),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_wsel(ex_wsel),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_wsel(mem_wsel),
    .ex_mispredict(ex_mispredict), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .perf_clr(perf_clr), .pc_write(a_pc), .ifid_write(a_ifid), .idex_write(a_idex),
    .exmem_write(a_exmem), .memwb_write(a_memwb), .ifid_flush(a_iff), .idex_flush(a_idf),
    .bubble(a_bub), .stall_cnt(a_stall), .flush_cnt(a_flush), .freeze_cnt(a_freeze)
  );

  hazard_ctrl #(.RAW(5), .ZERO_SKIP(0), .PCNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch), .id_jr(id_jr),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_wsel(ex_wsel),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_wsel(mem_wsel),
    .ex_mispredict(ex_mispredict), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .perf_clr(perf_clr), .pc_write(b_pc), .ifid_write(b_ifid), .idex_write(b_idex),
    .exmem_write(b_exmem), .memwb_write(b_memwb), .ifid_flush(b_iff), .idex_flush(b_idf),
    .bubble(b_bub), .stall_cnt(b_stall), .flush_cnt(b_flush), .freeze_cnt(b_freeze)
  );

  hazard_ctrl #(.RAW(5), .ZERO_SKIP(1), .PCNT_W(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch), .id_jr(id_jr),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_wsel(ex_wsel),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_wsel(mem_wsel),
    .ex_mispredict(ex_mispredict), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .perf_clr(perf_clr), .pc_write(c_pc), .ifid_write(c_ifid), .idex_write(c_idex),
    .exmem_write(c_exmem), .memwb_write(c_memwb), .ifid_flush(c_iff), .idex_flush(c_idf),
    .bubble(c_bub), .stall_cnt(c_stall), .flush_cnt(c_flush), .freeze_cnt(c_freeze)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_branch = 1'b0; id_jr = 1'b0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_wsel = '0;
    mem_regwrite = 1'b0; mem_memread = 1'b0; mem_wsel = '0;
    ex_mispredict = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; perf_clr = 1'b0;
  endtask

  // Advance one clock; inputs are driven 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    idle();
    perf_clr = 1'b1;
    cyc();
    perf_clr = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    // Reset state
    chk("reset_ctl", 32'(a_ctl), 32'(C_NORM));
    chk("reset_stall_cnt", 32'(a_stall), 32'd0);
    chk("reset_flush_cnt", 32'(a_flush), 32'd0);
    chk("reset_freeze_cnt", 32'(a_freeze), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Load-use: EX lw $8, ID add reads rs=8
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wsel = 5'd8;
    id_rs = 5'd8; id_use_rs = 1'b1;
    #1 chk("lu_stall", 32'(a_ctl), 32'(C_STALL));
    cyc();
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_wsel = '0;
    mem_memread = 1'b1; mem_regwrite = 1'b1; mem_wsel = 5'd8;
    #1 chk("lu_release", 32'(a_ctl), 32'(C_NORM));
    chk("lu_stall_cnt", 32'(a_stall), 32'd1);

    // Branch after load: EX lw $5, ID beq reads rt=5 -> two stall cycles
    clear_counters();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wsel = 5'd5;
    id_branch = 1'b1; id_rt = 5'd5; id_use_rt = 1'b1; id_rs = 5'd2; id_use_rs = 1'b1;
    #1 chk("bl_cycle1", 32'(a_ctl), 32'(C_STALL));
    cyc();
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_wsel = '0;
    mem_memread = 1'b1; mem_regwrite = 1'b1; mem_wsel = 5'd5;
    #1 chk("bl_cycle2_bm", 32'(a_ctl), 32'(C_STALL));
    cyc();
    mem_memread = 1'b0; mem_regwrite = 1'b0; mem_wsel = '0;
    #1 chk("bl_cycle3_go", 32'(a_ctl), 32'(C_NORM));
    chk("bl_stall_cnt", 32'(a_stall), 32'd2);

    // Branch depending on EX ALU result: bx only
    idle();
    ex_regwrite = 1'b1; ex_wsel = 5'd7;
    id_branch = 1'b1; id_rs = 5'd7; id_use_rs = 1'b1;
    #1 chk("bx_stall", 32'(a_ctl), 32'(C_STALL));
    // Same ALU producer but a non-branch consumer: forwarding covers it
    id_branch = 1'b0;
    #1 chk("alu_no_stall", 32'(a_ctl), 32'(C_NORM));

    // r0 exemption: load writing $0, ID reads rs=0
    idle();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wsel = 5'd0;
    id_rs = 5'd0; id_use_rs = 1'b1;
    #1 chk("r0_skip", 32'(a_ctl), 32'(C_NORM));
    chk("r0_noskip", 32'(b_ctl), 32'(C_STALL));
    // Matching register but use flag low: no hazard
    id_rs = 5'd9; ex_wsel = 5'd9; id_use_rs = 1'b0;
    #1 chk("no_use_flag", 32'(a_ctl), 32'(C_NORM));

    // jr: no hazard kills fetch slot; with hazard stalls first, flushes after
    idle();
    id_jr = 1'b1; id_branch = 1'b1; id_rs = 5'd9; id_use_rs = 1'b1;
    ex_regwrite = 1'b1; ex_wsel = 5'd3;
    #1 chk("jr_free", 32'(a_ctl), 32'(C_JR));
    ex_wsel = 5'd9;
    #1 chk("jr_hazard", 32'(a_ctl), 32'(C_STALL));
    cyc();
    ex_regwrite = 1'b0; ex_wsel = '0;
    #1 chk("jr_after", 32'(a_ctl), 32'(C_JR));

    // Mispredict during a 3-cycle dmem freeze, pulse in freeze cycle 1
    clear_counters();
    dmem_ready = 1'b0; ex_mispredict = 1'b1;
    #1 chk("frz_c1", 32'(a_ctl), 32'(C_FREEZE));
    cyc();
    ex_mispredict = 1'b0;
    #1 chk("frz_c2", 32'(a_ctl), 32'(C_FREEZE));
    cyc();
    #1 chk("frz_c3", 32'(a_ctl), 32'(C_FREEZE));
    cyc();
    dmem_ready = 1'b1;
    #1 chk("frz_release_redir", 32'(a_ctl), 32'(C_REDIR));
    chk("frz_freeze_cnt", 32'(a_freeze), 32'd3);
    cyc();
    #1 chk("frz_after_normal", 32'(a_ctl), 32'(C_NORM));
    chk("frz_flush_cnt", 32'(a_flush), 32'd1);
    chk("frz_freeze_cnt_hold", 32'(a_freeze), 32'd3);

    // Mispredict with simultaneous load-use: redirect wins
    clear_counters();
    ex_mispredict = 1'b1;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wsel = 5'd4;
    id_rt = 5'd4; id_use_rt = 1'b1;
    #1 chk("redir_vs_lu", 32'(a_ctl), 32'(C_REDIR));
    cyc();
    idle();
    #1 chk("redir_stall_cnt", 32'(a_stall), 32'd0);
    chk("redir_flush_cnt", 32'(a_flush), 32'd1);

    // Both memories waiting: one freeze count per clock
    imem_ready = 1'b0; dmem_ready = 1'b0;
    #1 chk("both_wait_ctl", 32'(a_ctl), 32'(C_FREEZE));
    cyc();
    imem_ready = 1'b1; dmem_ready = 1'b1;
    #1 chk("both_wait_cnt", 32'(a_freeze), 32'd1);

    // Counter saturation with PCNT_W=2: 5 stall cycles -> 3
    clear_counters();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wsel = 5'd6;
    id_rs = 5'd6; id_use_rs = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    #1 chk("sat_c_stall", 32'(c_stall), 32'd3);
    chk("sat_a_stall", 32'(a_stall), 32'd5);
    // Clear coincident with a stall
    perf_clr = 1'b1;
    #1 chk("clr_ctl", 32'(c_ctl), 32'(C_STALL));
    cyc();
    perf_clr = 1'b0;
    idle();
    #1 chk("clr_c_stall", 32'(c_stall), 32'd0);
    chk("clr_a_stall", 32'(a_stall), 32'd0);

    // Reset asserted mid-freeze with pending redirect discards it
    dmem_ready = 1'b0; ex_mispredict = 1'b1;
    cyc();
    ex_mispredict = 1'b0;
    #1 chk("rstfrz_frozen", 32'(a_freeze), 32'd1);
    rst_n = 1'b0;
    #1 chk("rstfrz_async_cnt", 32'(a_freeze), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    dmem_ready = 1'b1;
    #1 chk("rstfrz_no_bubble", 32'(a_ctl), 32'(C_NORM));
    cyc();
    #1 chk("rstfrz_flush_cnt", 32'(a_flush), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
